// File: rtl/aes_sbox_sched.sv
// AES SubWord scheduler: round-robin sharing of one S-box between the round datapath
// (requester 0) and key expansion (requester 1), one byte issued per cycle.
module aes_sbox_sched #(
   parameter int SBOX_LAT = 0
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic [1:0]  req_valid_i,
   output logic [1:0]  req_ready_o,
   input  logic [31:0] req0_data_i,
   input  logic [31:0] req1_data_i,
   input  logic [1:0]  req_inv_i,
   output logic [7:0]  sbox_data_o,
   output logic        sbox_inv_o,
   output logic        sbox_valid_o,
   input  logic [7:0]  sbox_data_i,
   output logic        rsp_valid_o,
   input  logic        rsp_ready_i,
   output logic [31:0] rsp_data_o,
   output logic        rsp_id_o,
   output logic        busy_o
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } state_e;

   state_e      state_q, state_d;
   logic [1:0]  cnt_q;
   logic        last_gnt_q;
   logic [31:0] op_q;
   logic        inv_q;
   logic        id_q;
   logic [31:0] rsp_data_q;

   logic        gnt_id;
   logic        accept;

   logic        vld_p0;
   logic [1:0]  idx_p0;
   logic        vld_p1;
   logic [1:0]  idx_p1;
   logic        cap_vld;
   logic [1:0]  cap_idx;

   // On a tie the requester that was not granted last wins
   always_comb begin
      gnt_id = 1'b0;
      case (req_valid_i)
         2'b10:   gnt_id = 1'b1;
         2'b11:   gnt_id = ~last_gnt_q;
         default: gnt_id = 1'b0;
      endcase
   end

   always_comb begin
      state_d      = state_q;
      accept       = 1'b0;
      req_ready_o  = 2'b00;
      sbox_valid_o = 1'b0;
      sbox_data_o  = 8'h00;
      sbox_inv_o   = 1'b0;
      rsp_valid_o  = 1'b0;
      busy_o       = 1'b1;
      case (state_q)
         IDLE: begin
            busy_o = 1'b0;
            // Gated by rst_ni so ready cannot follow req_valid_i while reset is held
            if (rst_ni && (req_valid_i != 2'b00)) begin
               accept      = 1'b1;
               req_ready_o = gnt_id ? 2'b10 : 2'b01;
               state_d     = ISSUE;
            end
         end
         ISSUE: begin
            sbox_valid_o = 1'b1;
            sbox_data_o  = op_q[{cnt_q, 3'b000} +: 8];
            sbox_inv_o   = inv_q;
            if (cnt_q == 2'd3) begin
               state_d = (SBOX_LAT == 1) ? DRAIN : DONE;
            end
         end
         DRAIN: begin
            state_d = DONE;
         end
         DONE: begin
            rsp_valid_o = 1'b1;
            if (rsp_ready_i) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q    <= IDLE;
         cnt_q      <= 2'd0;
         last_gnt_q <= 1'b1;
         op_q       <= 32'h0;
         inv_q      <= 1'b0;
         id_q       <= 1'b0;
      end else begin
         state_q <= state_d;
         if (accept) begin
            op_q       <= gnt_id ? req1_data_i : req0_data_i;
            inv_q      <= req_inv_i[gnt_id];
            id_q       <= gnt_id;
            last_gnt_q <= gnt_id;
            cnt_q      <= 2'd0;
         end else if (state_q == ISSUE) begin
            cnt_q <= cnt_q + 2'd1;
         end
      end
   end

   // Capture stage boundary: p0 is the issue cycle, p1 the cycle after it
   assign vld_p0 = (state_q == ISSUE);
   assign idx_p0 = cnt_q;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         vld_p1 <= 1'b0;
      end else begin
         vld_p1 <= vld_p0;
      end
   end

   always_ff @(posedge clk_i) begin
      idx_p1 <= idx_p0;
   end

   assign cap_vld = (SBOX_LAT == 1) ? vld_p1 : vld_p0;
   assign cap_idx = (SBOX_LAT == 1) ? idx_p1 : idx_p0;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         rsp_data_q <= 32'h0;
      end else if (cap_vld) begin
         rsp_data_q[{cap_idx, 3'b000} +: 8] <= sbox_data_i;
      end
   end

   assign rsp_data_o = rsp_data_q;
   assign rsp_id_o   = id_q;

endmodule

// File: tb/tb_aes_sbox_sched.sv
// Bench for aes_sbox_sched: one instance per S-box latency, each with its own S-box model
// and a per-cycle reference monitor, driven by vector tables, directed sequences and random traffic.
`timescale 1ns/1ps
module tb_aes_sbox_sched;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   logic        rst_n;
   logic [1:0]  req_valid [2];
   logic [1:0]  req_ready [2];
   logic [31:0] req0_data [2];
   logic [31:0] req1_data [2];
   logic [1:0]  req_inv   [2];
   logic [7:0]  sb_data   [2];
   logic        sb_inv    [2];
   logic        sb_valid  [2];
   logic        rsp_valid [2];
   logic        rsp_ready [2];
   logic [31:0] rsp_data  [2];
   logic        rsp_id    [2];
   logic        busy      [2];
   logic [7:0]  sb_rsp0;
   logic [7:0]  sb_rsp1;

   logic [7:0]  fwd_tab [256];
   logic [7:0]  inv_tab [256];

   int n_tests = 0;
   int n_fail  = 0;

   aes_sbox_sched #(.SBOX_LAT(0)) u_dut0 (
      .clk_i(clk), .rst_ni(rst_n),
      .req_valid_i(req_valid[0]), .req_ready_o(req_ready[0]),
      .req0_data_i(req0_data[0]), .req1_data_i(req1_data[0]), .req_inv_i(req_inv[0]),
      .sbox_data_o(sb_data[0]), .sbox_inv_o(sb_inv[0]), .sbox_valid_o(sb_valid[0]),
      .sbox_data_i(sb_rsp0),
      .rsp_valid_o(rsp_valid[0]), .rsp_ready_i(rsp_ready[0]),
      .rsp_data_o(rsp_data[0]), .rsp_id_o(rsp_id[0]), .busy_o(busy[0])
   );

   aes_sbox_sched #(.SBOX_LAT(1)) u_dut1 (
      .clk_i(clk), .rst_ni(rst_n),
      .req_valid_i(req_valid[1]), .req_ready_o(req_ready[1]),
      .req0_data_i(req0_data[1]), .req1_data_i(req1_data[1]), .req_inv_i(req_inv[1]),
      .sbox_data_o(sb_data[1]), .sbox_inv_o(sb_inv[1]), .sbox_valid_o(sb_valid[1]),
      .sbox_data_i(sb_rsp1),
      .rsp_valid_o(rsp_valid[1]), .rsp_ready_i(rsp_ready[1]),
      .rsp_data_o(rsp_data[1]), .rsp_id_o(rsp_id[1]), .busy_o(busy[1])
   );

   // GF(2^8) arithmetic behind the AES S-box, used to build both lookup tables
   function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b);
      logic [7:0] a;
      logic [7:0] p;
      a = a_in;
      p = 8'h00;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ a;
         a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1B : 8'h00);
      end
      return p;
   endfunction

   function automatic logic [7:0] ginv(input logic [7:0] a);
      if (a == 8'h00) return 8'h00;
      for (int x = 1; x < 256; x++) begin
         if (gmul(a, 8'(x)) == 8'h01) return 8'(x);
      end
      return 8'h00;
   endfunction

   function automatic logic [7:0] rotl(input logic [7:0] x, input int n);
      return (x << n) | (x >> (8 - n));
   endfunction

   function automatic logic [31:0] sub_word(input logic [31:0] w, input logic inv);
      logic [31:0] r;
      for (int i = 0; i < 4; i++) begin
         r[8*i +: 8] = inv ? inv_tab[w[8*i +: 8]] : fwd_tab[w[8*i +: 8]];
      end
      return r;
   endfunction

   function automatic logic [1:0] rr_pick(input logic [1:0] v, input logic last_gnt);
      if (v == 2'b11) return last_gnt ? 2'b01 : 2'b10;
      return v;
   endfunction

   task automatic check(input string name, input int d, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL d%0d %s: got %0h expected %0h (cycle %0d)", d, name, act, exp, cyc);
      end
   endtask

   // Shared S-box stand-ins: combinational for latency 0, one register for latency 1
   assign sb_rsp0 = sb_valid[0] ? (sb_inv[0] ? inv_tab[sb_data[0]] : fwd_tab[sb_data[0]]) : 8'hA5;
   always @(posedge clk)
      sb_rsp1 <= sb_valid[1] ? (sb_inv[1] ? inv_tab[sb_data[1]] : fwd_tab[sb_data[1]]) : 8'hA5;

   // Reference monitor: tracks one outstanding SubWord per instance and the expected timeline
   for (genvar g = 0; g < 2; g++) begin : g_mon
      int n_acc = 0;
      int n_rsp = 0;
      initial begin
         logic        m_last;
         logic        pend;
         int          acc_c;
         logic [31:0] op;
         logic        inv;
         logic        id;
         int          age;
         logic [1:0]  er;
         logic        ev;
         logic        rv;
         logic        gid;
         m_last = 1'b1;
         pend   = 1'b0;
         acc_c  = 0;
         op     = 32'h0;
         inv    = 1'b0;
         id     = 1'b0;
         forever begin
            @(negedge clk);
            if (!rst_n) begin
               check("reset_outputs_zero", g, 32'(|{req_ready[g], rsp_valid[g], rsp_data[g], rsp_id[g],
                     sb_valid[g], sb_data[g], sb_inv[g], busy[g]}), 32'h0);
               if (pend) n_acc--;
               pend   = 1'b0;
               m_last = 1'b1;
            end else begin
               age = cyc - acc_c;
               er  = pend ? 2'b00 : rr_pick(req_valid[g], m_last);
               check("req_ready", g, 32'(req_ready[g]), 32'(er));
               check("busy", g, 32'(busy[g]), 32'(pend));
               ev = pend && (age >= 1) && (age <= 4);
               check("sbox_valid", g, 32'(sb_valid[g]), 32'(ev));
               if (ev) begin
                  check("sbox_data", g, 32'(sb_data[g]), (op >> (8 * (age - 1))) & 32'hFF);
                  check("sbox_inv", g, 32'(sb_inv[g]), 32'(inv));
               end else begin
                  check("sbox_idle_zero", g, 32'({sb_data[g], sb_inv[g]}), 32'h0);
               end
               rv = pend && (age >= 5 + g);
               check("rsp_valid", g, 32'(rsp_valid[g]), 32'(rv));
               if (rv) begin
                  check("rsp_data", g, rsp_data[g], sub_word(op, inv));
                  check("rsp_id", g, 32'(rsp_id[g]), 32'(id));
               end
               if (rv && rsp_ready[g]) begin
                  pend = 1'b0;
                  n_rsp++;
               end else if (!pend && (er != 2'b00)) begin
                  gid    = er[1];
                  pend   = 1'b1;
                  acc_c  = cyc;
                  op     = gid ? req1_data[g] : req0_data[g];
                  inv    = req_inv[g][gid];
                  id     = gid;
                  m_last = gid;
                  n_acc++;
               end
            end
         end
      end
   end

   typedef struct {
      int          lat;
      bit          rid;
      logic [31:0] data;
      bit          inv;
      logic [31:0] exp;
   } vec_t;

   vec_t vecs [6];

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      step();
      rst_n = 1'b0;
      step();
      step();
      rst_n = 1'b1;
   endtask

   task automatic wait_idle(input int d);
      bit ok;
      ok = 1'b0;
      rsp_ready[d] = 1'b1;
      for (int i = 0; i < 40 && !ok; i++) begin
         @(negedge clk);
         if (!busy[d]) ok = 1'b1;
      end
      check("idle_timeout", d, 32'(ok), 32'h1);
   endtask

   task automatic run_vec(input vec_t v);
      int d;
      int acc;
      bit seen;
      d = v.lat;
      acc = 0;
      step();
      rsp_ready[d] = 1'b1;
      if (v.rid) begin
         req1_data[d] = v.data;
         req0_data[d] = ~v.data;
         req_inv[d]   = {v.inv, ~v.inv};
         req_valid[d] = 2'b10;
      end else begin
         req0_data[d] = v.data;
         req1_data[d] = ~v.data;
         req_inv[d]   = {~v.inv, v.inv};
         req_valid[d] = 2'b01;
      end
      seen = 1'b0;
      for (int i = 0; i < 20 && !seen; i++) begin
         @(negedge clk);
         if (req_ready[d] != 2'b00) begin
            seen = 1'b1;
            acc  = cyc;
            check("vec_grant", d, 32'(req_ready[d]), 32'(req_valid[d]));
         end
      end
      check("vec_accept_timeout", d, 32'(seen), 32'h1);
      step();
      req_valid[d] = 2'b00;
      seen = 1'b0;
      for (int i = 0; i < 20 && !seen; i++) begin
         @(negedge clk);
         if (rsp_valid[d]) begin
            seen = 1'b1;
            check("vec_latency", d, cyc - acc, 5 + d);
            check("vec_rsp_data", d, rsp_data[d], v.exp);
            check("vec_rsp_id", d, 32'(rsp_id[d]), 32'(v.rid));
         end
      end
      check("vec_rsp_timeout", d, 32'(seen), 32'h1);
      step();
      step();
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish within its time limit");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [7:0]  b;
      logic [7:0]  c;
      int          order [$];
      int          gap;
      int          maxgap;
      int          rv_seen;
      bit          seen;
      logic [31:0] d0;
      logic        i0;

      for (int i = 0; i < 256; i++) begin
         b = ginv(8'(i));
         fwd_tab[i] = b ^ rotl(b, 1) ^ rotl(b, 2) ^ rotl(b, 3) ^ rotl(b, 4) ^ 8'h63;
         c = rotl(8'(i), 1) ^ rotl(8'(i), 3) ^ rotl(8'(i), 6) ^ 8'h05;
         inv_tab[i] = ginv(c);
      end

      vecs[0] = '{lat: 0, rid: 1'b0, data: 32'h00010253, inv: 1'b0, exp: 32'h637C77ED};
      vecs[1] = '{lat: 1, rid: 1'b1, data: 32'h63636363, inv: 1'b1, exp: 32'h00000000};
      vecs[2] = '{lat: 0, rid: 1'b1, data: 32'h11223344, inv: 1'b0, exp: 32'h8293C31B};
      vecs[3] = '{lat: 1, rid: 1'b0, data: 32'hFFFFFFFF, inv: 1'b0, exp: 32'h16161616};
      vecs[4] = '{lat: 0, rid: 1'b0, data: 32'h16161616, inv: 1'b1, exp: 32'hFFFFFFFF};
      vecs[5] = '{lat: 1, rid: 1'b0, data: 32'h8293C31B, inv: 1'b1, exp: 32'h11223344};

      rst_n = 1'b0;
      for (int d = 0; d < 2; d++) begin
         req_valid[d] = 2'b00;
         req0_data[d] = 32'h0;
         req1_data[d] = 32'h0;
         req_inv[d]   = 2'b00;
         rsp_ready[d] = 1'b0;
      end
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;

      foreach (vecs[i]) run_vec(vecs[i]);

      // Continuous contention on the latency-0 instance from a fresh pointer
      do_reset();
      req0_data[0] = 32'hA0A1A2A3;
      req1_data[0] = 32'hB0B1B2B3;
      req_inv[0]   = 2'b10;
      rsp_ready[0] = 1'b1;
      req_valid[0] = 2'b11;
      gap = 0;
      maxgap = 0;
      for (int i = 0; i < 60 && order.size() < 4; i++) begin
         @(negedge clk);
         if (req_ready[0] != 2'b00) order.push_back(int'(req_ready[0][1]));
         if (order.size() > 0) begin
            if (!busy[0]) begin
               gap++;
               if (gap > maxgap) maxgap = gap;
            end else begin
               gap = 0;
            end
         end
      end
      check("rr_accept_count", 0, order.size(), 4);
      for (int i = 0; i < order.size(); i++) check("rr_order", 0, order[i], i % 2);
      check("rr_busy_gap_le1", 0, 32'(maxgap <= 1), 32'h1);
      step();
      req_valid[0] = 2'b00;
      wait_idle(0);

      // Response back-pressure on the latency-1 instance
      step();
      req1_data[1] = 32'h0F1E2D3C;
      req_inv[1]   = 2'b00;
      rsp_ready[1] = 1'b0;
      req_valid[1] = 2'b10;
      seen = 1'b0;
      for (int i = 0; i < 20 && !seen; i++) begin
         @(negedge clk);
         if (req_ready[1] != 2'b00) seen = 1'b1;
      end
      check("stall_accept_timeout", 1, 32'(seen), 32'h1);
      step();
      req_valid[1] = 2'b11;
      req0_data[1] = 32'h12345678;
      req1_data[1] = 32'h9ABCDEF0;
      seen = 1'b0;
      d0 = 32'h0;
      i0 = 1'b0;
      for (int i = 0; i < 20 && !seen; i++) begin
         @(negedge clk);
         if (rsp_valid[1]) begin
            seen = 1'b1;
            d0 = rsp_data[1];
            i0 = rsp_id[1];
         end
      end
      check("stall_rsp_timeout", 1, 32'(seen), 32'h1);
      check("stall_rsp_data", 1, d0, 32'h7672D8EB);
      check("stall_rsp_id", 1, 32'(i0), 32'h1);
      repeat (10) begin
         @(negedge clk);
         check("stall_valid_held", 1, 32'(rsp_valid[1]), 32'h1);
         check("stall_data_stable", 1, rsp_data[1], d0);
         check("stall_id_stable", 1, 32'(rsp_id[1]), 32'(i0));
         check("stall_no_ready", 1, 32'(req_ready[1]), 32'h0);
         check("stall_no_issue", 1, 32'(sb_valid[1]), 32'h0);
      end
      step();
      req_valid[1] = 2'b00;
      wait_idle(1);

      // Reset in the third issue cycle after a requester-0 grant
      run_vec(vecs[0]);
      step();
      req0_data[0] = 32'hDEADBEEF;
      req_inv[0]   = 2'b00;
      rsp_ready[0] = 1'b1;
      req_valid[0] = 2'b01;
      seen = 1'b0;
      for (int i = 0; i < 20 && !seen; i++) begin
         @(negedge clk);
         if (req_ready[0] != 2'b00) seen = 1'b1;
      end
      check("rst_txn_accept_timeout", 0, 32'(seen), 32'h1);
      @(posedge clk);
      #1 req_valid[0] = 2'b00;
      @(posedge clk);
      @(posedge clk);
      #2;
      check("k2_issue_valid", 0, 32'(sb_valid[0]), 32'h1);
      check("k2_issue_byte", 0, 32'(sb_data[0]), 32'hAD);
      rst_n = 1'b0;
      #1;
      check("async_rst_zero", 0, 32'(|{req_ready[0], rsp_valid[0], rsp_data[0], rsp_id[0],
            sb_valid[0], sb_data[0], sb_inv[0], busy[0]}), 32'h0);
      @(negedge clk);
      @(posedge clk);
      #1 rst_n = 1'b1;
      rv_seen = 0;
      repeat (10) begin
         @(negedge clk);
         if (rsp_valid[0]) rv_seen++;
      end
      check("abandoned_no_rsp", 0, rv_seen, 0);
      step();
      req_valid[0] = 2'b11;
      @(negedge clk);
      check("tie_after_reset", 0, 32'(req_ready[0]), 32'h1);
      step();
      req_valid[0] = 2'b00;
      wait_idle(0);

      // Random traffic on both instances, checked cycle by cycle by the monitors
      for (int i = 0; i < 10000; i++) begin
         step();
         for (int d = 0; d < 2; d++) begin
            req_valid[d] = 2'($urandom_range(0, 3));
            req0_data[d] = $urandom;
            req1_data[d] = $urandom;
            req_inv[d]   = 2'($urandom_range(0, 3));
            rsp_ready[d] = ($urandom_range(0, 3) != 0);
         end
      end
      step();
      for (int d = 0; d < 2; d++) begin
         req_valid[d] = 2'b00;
         rsp_ready[d] = 1'b1;
      end
      repeat (20) @(negedge clk);
      check("no_lost_rsp", 0, g_mon[0].n_rsp, g_mon[0].n_acc);
      check("no_lost_rsp", 1, g_mon[1].n_rsp, g_mon[1].n_acc);
      check("random_progress", 0, 32'(g_mon[0].n_rsp >= 300), 32'h1);
      check("random_progress", 1, 32'(g_mon[1].n_rsp >= 300), 32'h1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
